// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect inputs, instruction-memory port,
// and the values handed to the F/D pipeline register.
interface fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  modport master (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, instr_out, pc_out, fetch_fault, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, instr_out, pc_out, fetch_fault, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, applies stall/redirect priority and
// buffers a redirect that arrives while the pipeline is frozen.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES = 32'h0000_4000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.slave fif
);

  // 33-bit end address so a window touching the top of memory cannot wrap
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] fetch_count;
  logic        fault;

  always_comb begin
    fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_END);
  end

  assign fif.imem_addr   = pc;
  assign fif.pc_out      = pc;
  assign fif.fetch_fault = fault;
  assign fif.instr_out   = fault ? 32'h0 : fif.imem_rdata;
  assign fif.fetch_count = fetch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      fetch_count <= 32'h0;
    end else if (fif.stall) begin
      // newest redirect seen during a freeze wins
      if (fif.redirect_valid) begin
        pend_valid  <= 1'b1;
        pend_target <= fif.redirect_target;
      end
    end else begin
      fetch_count <= fetch_count + 32'd1;
      pend_valid  <= 1'b0;
      if (fif.redirect_valid)
        pc <= fif.redirect_target;
      else if (pend_valid)
        pc <= pend_target;
      else
        pc <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
  logic clk;
  logic reset;

  fetch_stage_if fif();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .fif   (fif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] NOP_W = 32'h2408_0001;

  task automatic add(input logic r, input logic s, input logic v, input logic [31:0] t,
                     input logic [31:0] epc, input logic ef, input logic [31:0] ec);
    vec_t x;
    x.rst = r; x.stl = s; x.rv = v; x.tgt = t; x.rdata = NOP_W;
    x.exp_pc = epc; x.exp_fault = ef; x.exp_instr = ef ? 32'h0 : NOP_W; x.exp_cnt = ec;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v,
                       input logic [31:0] t, input logic [31:0] rd);
    reset = r; fif.stall = s; fif.redirect_valid = v;
    fif.redirect_target = t; fif.imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  // behavioural model state
  longint unsigned m_pc;
  bit              m_have_pend;
  longint unsigned m_pend;
  longint unsigned m_cnt;

  function automatic bit model_fault(longint unsigned p);
    return (p % 4 != 0) || (p < 64'h3000) || (p >= 64'h3000 + 64'h4000);
  endfunction

  task automatic model_step(input bit r, input bit s, input bit v, input logic [31:0] t);
    if (r) begin
      m_pc = 64'h3000; m_have_pend = 0; m_pend = 0; m_cnt = 0;
    end else if (s) begin
      if (v) begin m_have_pend = 1; m_pend = t; end
    end else begin
      if (v)                m_pc = t;
      else if (m_have_pend) m_pc = m_pend;
      else                  m_pc = (m_pc + 4) % (64'd1 << 32);
      m_have_pend = 0;
      m_cnt = (m_cnt + 1) % (64'd1 << 32);
    end
  endtask

  initial begin
    reset = 1'b1; fif.stall = 1'b0; fif.redirect_valid = 1'b0;
    fif.redirect_target = 32'h0; fif.imem_rdata = NOP_W;

    //  rst stl rv tgt            pc            flt cnt
    add(1, 0, 0, 32'h0,          32'h3000,     0, 0);
    add(0, 0, 0, 32'h0,          32'h3004,     0, 1);
    add(0, 0, 0, 32'h0,          32'h3008,     0, 2);
    add(0, 0, 0, 32'h0,          32'h300C,     0, 3);
    add(1, 0, 0, 32'h0,          32'h3000,     0, 0);
    add(0, 0, 0, 32'h0,          32'h3004,     0, 1);
    add(0, 0, 0, 32'h0,          32'h3008,     0, 2);
    add(0, 0, 1, 32'h3040,       32'h3040,     0, 3);
    add(0, 0, 0, 32'h0,          32'h3044,     0, 4);
    add(0, 1, 1, 32'h3100,       32'h3044,     0, 4);
    add(0, 1, 0, 32'h0,          32'h3044,     0, 4);
    add(0, 0, 0, 32'h0,          32'h3100,     0, 5);
    add(0, 0, 0, 32'h0,          32'h3104,     0, 6);
    add(0, 1, 1, 32'h3100,       32'h3104,     0, 6);
    add(0, 1, 1, 32'h3200,       32'h3104,     0, 6);
    add(0, 0, 0, 32'h0,          32'h3200,     0, 7);
    add(0, 1, 1, 32'h3100,       32'h3200,     0, 7);
    add(0, 0, 1, 32'h3300,       32'h3300,     0, 8);
    add(0, 0, 0, 32'h0,          32'h3304,     0, 9);
    add(0, 0, 1, 32'h3002,       32'h3002,     1, 10);
    add(0, 0, 0, 32'h0,          32'h3006,     1, 11);
    add(0, 0, 1, 32'h7000,       32'h7000,     1, 12);
    add(0, 0, 0, 32'h0,          32'h7004,     1, 13);
    add(0, 0, 1, 32'h6FFC,       32'h6FFC,     0, 14);
    add(0, 0, 0, 32'h0,          32'h7000,     1, 15);
    add(0, 0, 1, 32'h2FFC,       32'h2FFC,     1, 16);
    add(0, 0, 1, 32'h3100,       32'h3100,     0, 17);
    add(0, 1, 1, 32'h3400,       32'h3100,     0, 17);
    add(1, 1, 0, 32'h0,          32'h3000,     0, 0);
    add(0, 0, 0, 32'h0,          32'h3004,     0, 1);
    add(0, 0, 0, 32'h0,          32'h3008,     0, 2);
    add(0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1, 3);
    add(0, 0, 0, 32'h0,          32'h0000_0000, 1, 4);
    add(0, 0, 1, 32'h3000,       32'h3000,     0, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt, vecs[i].rdata);
      chk($sformatf("vec%0d pc_out", i),    fif.pc_out,             vecs[i].exp_pc);
      chk($sformatf("vec%0d imem_addr", i), fif.imem_addr,          vecs[i].exp_pc);
      chk($sformatf("vec%0d fault", i),     {31'h0, fif.fetch_fault}, {31'h0, vecs[i].exp_fault});
      chk($sformatf("vec%0d instr", i),     fif.instr_out,          vecs[i].exp_instr);
      chk($sformatf("vec%0d count", i),     fif.fetch_count,        vecs[i].exp_cnt);
    end

    // randomized traffic against the model
    model_step(1, 0, 0, 32'h0);
    drive(1, 0, 0, 32'h0, NOP_W);
    for (int n = 0; n < 3000; n++) begin
      bit          r, s, v;
      logic [31:0] t, rd;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 99) < 30);
      v  = ($urandom_range(0, 99) < 20);
      rd = $urandom;
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
        2:       t = 32'h6FF8 + 32'($urandom_range(0, 15));
        default: t = 32'h2FF8 + 32'($urandom_range(0, 15));
      endcase
      model_step(r, s, v, t);
      drive(r, s, v, t, rd);
      chk("rnd pc_out", fif.pc_out, m_pc[31:0]);
      chk("rnd imem_addr", fif.imem_addr, m_pc[31:0]);
      chk("rnd fault", {31'h0, fif.fetch_fault}, {31'h0, model_fault(m_pc)});
      chk("rnd instr", fif.instr_out, model_fault(m_pc) ? 32'h0 : rd);
      chk("rnd count", fif.fetch_count, m_cnt[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (F) stage of the 5-stage pipelined MIPS core.
- Owns the program counter and drives the instruction-memory address.
- Supplies instr_out/pc_out to the F/D pipeline register, which latches them unless frozen.
- Accepts stall from the hazard unit and branch/jump redirects resolved in D; buffers a redirect that arrives while stalled.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_BYTES, 32'h0000_4000, size of the legal fetch window in bytes; legal range is [IM_BASE, IM_BASE+IM_BYTES).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit freeze; same signal that freezes the F/D register.
- redirect_valid  input  1  D-stage branch taken or jump; one-cycle pulse.
- redirect_target  input  32  target PC accompanying redirect_valid.
- imem_addr  output  32  instruction-memory byte address; equals pc, combinational.
- imem_rdata  input  32  instruction word at imem_addr, combinational read.
- instr_out  output  32  instruction to the F/D register; 0 (nop) on fault.
- pc_out  output  32  PC of instr_out.
- fetch_fault  output  1  current pc is misaligned or outside the legal window.
- fetch_count  output  32  number of cycles the PC advanced or redirected, excluding stalled cycles.

Behaviour:
- State: pc[31:0], pend_valid, pend_target[31:0], fetch_count[31:0].
- Reset, checked every posedge, overrides everything:
  - pc=RESET_PC, pend_valid=0, pend_target=0, fetch_count=0.
  - Outputs after reset: imem_addr=pc_out=32'h3000, fetch_fault=0 with default params, instr_out=imem_rdata.
- Combinational outputs:
  - imem_addr = pc; pc_out = pc.
  - fetch_fault = (pc[1:0]!=0) | (pc < IM_BASE) | (pc >= IM_BASE+IM_BYTES).
  - Range compare is unsigned 32-bit. IM_BASE+IM_BYTES is computed in 33 bits so there is no wrap at the top of the address space.
  - instr_out = fetch_fault ? 32'h0 : imem_rdata.
- Next-PC priority at posedge when reset=0:
  1. stall=1: pc holds and fetch_count holds. If redirect_valid, then pend_valid=1 and pend_target=redirect_target; a newer redirect overwrites the pending one.
  2. stall=0 and redirect_valid=1: pc=redirect_target, pend_valid=0, and fetch_count increments. A live redirect beats a pending one.
  3. stall=0, pend_valid=1: pc=pend_target, pend_valid=0, and fetch_count increments.
  4. Otherwise: pc=pc+4 modulo 2^32, and fetch_count increments.
- Latency:
  - A redirect seen at edge N makes pc=target visible in cycle N+1.
  - The instruction fetched in the redirect cycle is the delay slot and is passed on normally; this stage performs no flush.
- Fault handling:
  - A faulting pc still advances by +4 and can still be redirected.
  - The fault is not sticky; fetch_fault is purely a function of the current pc.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-stall with a pending redirect discards the pending target.
- redirect_target is not checked at capture time; a bad target only raises fetch_fault once it becomes pc.

Test Plan:
- Reset, then 3 free-running cycles with imem_rdata=32'h2408_0001 → pc_out 3000, 3004, 3008, 300C; instr_out=32'h2408_0001; fetch_fault=0; fetch_count=3.
- At pc=3008 pulse redirect_valid with target=32'h3040, stall=0 → next cycle pc_out=3040, pend_valid=0, fetch_count incremented once.
- Hold stall=1 for 2 cycles at pc=300C and pulse redirect 32'h3100 during the first stall cycle, then release → pc stays 300C for 2 cycles, then becomes 3100.
- While stalled with pending target 3100, pulse a second redirect to 3200; release stall → pc=3200. Separately, with pending 3100, stall=0 and a live redirect to 3300 → pc=3300.
- Redirect to 32'h3002 → fetch_fault=1, instr_out=0, next pc=3006 (still faulting). Redirect to 32'h7000 → fetch_fault=1. Redirect to 32'h6FFC → fetch_fault=0.
- Assert reset during stall with a pending redirect → next cycle pc=3000, pend_valid=0, fetch_count=0; after release, pc advances to 3004 and the pending target is never taken.
